// File: rtl/missile_launcher.sv
// missile_launcher
//   Turns the player fire key into one-cycle, one-hot shot strobes, one bit per
//   missile slot. Enforces a frame-based cooldown after every shot and steers
//   each shot to the lowest-numbered free slot.
//
//   Parameters
//     N_MISSILES       number of missile slots (1..8)
//     COOLDOWN_FRAMES  frames after a shot before the next one is accepted (0 = none)
//
//   Ports
//     clk             system clock
//     resetN          asynchronous, active-low reset
//     startOfFrame    one-cycle pulse per video frame
//     enable          game running; low forces the launcher idle
//     fire_key        debounced fire button level, 1 = pressed
//     missile_active  per-slot active flag returned by missile_movement
//     shooting_pulse  one-hot, one-cycle shot strobe to slot i
//     ready           a shot would be accepted this cycle
//     shots_fired     saturating count of issued shots
//
//   Build option
//     AUTO_FIRE_EN    when defined, a held key re-fires (level-triggered request)
module missile_launcher #(
    parameter int unsigned N_MISSILES      = 4,
    parameter int unsigned COOLDOWN_FRAMES = 8
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic                  enable,
    input  logic                  fire_key,
    input  logic [N_MISSILES-1:0] missile_active,
    output logic [N_MISSILES-1:0] shooting_pulse,
    output logic                  ready,
    output logic [15:0]           shots_fired
);

    typedef enum logic [1:0] {
        ST_READY,
        ST_FIRE,
        ST_COOLDOWN
    } state_t;

    localparam logic [7:0] CD_LOAD = 8'(COOLDOWN_FRAMES);

    state_t                     state_q, state_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic                       key_prev_q, key_prev_d;
    logic [N_MISSILES-1:0]      pending_q, pending_d;
    logic [N_MISSILES-1:0][1:0] age_q, age_d;
    logic [N_MISSILES-1:0]      pulse_q, pulse_d;
    logic [15:0]                shots_q, shots_d;

    logic                       fire_req;
    logic [N_MISSILES-1:0]      free;
    logic [N_MISSILES-1:0]      sel;
    logic [N_MISSILES-1:0]      issue;

`ifdef AUTO_FIRE_EN
    assign fire_req = fire_key;
`else
    assign fire_req = fire_key & ~key_prev_q;
`endif

    assign free = ~missile_active & ~pending_q;
    // Isolate the lowest set bit of free: x & -x keeps only the least significant one.
    assign sel  = free & (-free);

    assign ready          = (state_q == ST_READY) & enable & (|free);
    assign shooting_pulse = pulse_q;
    assign shots_fired    = shots_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pulse_d    = '0;
        shots_d    = shots_q;
        issue      = '0;
        key_prev_d = fire_key;

        unique case (state_q)
            ST_READY: begin
                if (enable && fire_req && (|free)) begin
                    state_d = ST_FIRE;
                    pulse_d = sel;
                    issue   = sel;
                end
            end
            ST_FIRE: begin
                if (shots_q != 16'hFFFF) begin
                    shots_d = shots_q + 16'd1;
                end
                if (COOLDOWN_FRAMES == 0) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_COOLDOWN;
                    cnt_d   = CD_LOAD;
                end
            end
            ST_COOLDOWN: begin
                // The frame that finds the counter already at zero ends the
                // cooldown, so a shot is followed by COOLDOWN_FRAMES+1 frames.
                if (startOfFrame) begin
                    if (cnt_q == '0) begin
                        state_d = ST_READY;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase

        // A pulse already registered still goes out; only future shots stop.
        if (!enable) begin
            state_d = ST_READY;
            cnt_d   = '0;
        end
    end

    // pending bridges the gap until missile_movement raises missile_active;
    // it also ages out on the second frame after issue if the slot never rises.
    always_comb begin
        pending_d = pending_q;
        age_d     = age_q;
        for (int unsigned i = 0; i < N_MISSILES; i++) begin
            if (issue[i]) begin
                pending_d[i] = 1'b1;
                age_d[i]     = 2'd0;
            end else if (pending_q[i]) begin
                if (missile_active[i]) begin
                    pending_d[i] = 1'b0;
                    age_d[i]     = 2'd0;
                end else if (startOfFrame) begin
                    if (age_q[i] == 2'd1) begin
                        pending_d[i] = 1'b0;
                        age_d[i]     = 2'd0;
                    end else begin
                        age_d[i] = age_q[i] + 2'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_READY;
            cnt_q      <= '0;
            key_prev_q <= 1'b1;
            pending_q  <= '0;
            age_q      <= '0;
            pulse_q    <= '0;
            shots_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_prev_q <= key_prev_d;
            pending_q  <= pending_d;
            age_q      <= age_d;
            pulse_q    <= pulse_d;
            shots_q    <= shots_d;
        end
    end

endmodule
